// File: rtl/mfp_spi_sensor_sequencer.sv
// SPI read sequencer for a 16-bit sensor ADC: on request or periodic auto-trigger,
// clocks one frame in MSB first and publishes it as frame and sample.
module mfp_spi_sensor_sequencer #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned AUTO_PERIOD = 250000
) (
  input  logic        SI_ClkIn,
  input  logic        SI_Reset,
  input  logic        req,
  input  logic        auto_en,
  input  logic        SPI_SDO,
  output logic        SPI_CS,
  output logic        SPI_SCK,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame,
  output logic [7:0]  sample
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]  DIV_Q    = 8'(CLK_DIV);
  localparam logic [23:0] PER_LAST = 24'(AUTO_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  half_q, half_d;
  logic        sck_q, sck_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] frame_q, frame_d;
  logic        done_q, done_d;
  logic [23:0] timer_q, timer_d;
  logic        pend_q, pend_d;
  logic        start, wrap;

  assign start = (state_q == IDLE) && (req || pend_q);
  assign wrap  = auto_en && (timer_q == PER_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sck_d   = sck_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    timer_d = (auto_en && !wrap) ? timer_q + 24'd1 : 24'd0;
    // A start swallows a wrap in the same cycle, so the two never yield two reads.
    pend_d  = (!auto_en || start) ? 1'b0 : (wrap ? 1'b1 : pend_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = 8'd0;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
          half_d  = 5'd0;
          sck_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = 8'd0;
          if (half_q == 5'd31) begin
            state_d = HOLD;
            sck_d   = 1'b1;
          end else begin
            half_d = half_q + 5'd1;
            sck_d  = ~sck_q;
            if (!sck_q) shreg_d = {shreg_q[14:0], SPI_SDO};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = QUIET;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          frame_d = shreg_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      QUIET: begin
        // The done cycle plus CLK_DIV further cycles of CS-high recovery.
        if (cnt_q == DIV_Q) state_d = IDLE;
        else                cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      half_q  <= 5'd0;
      sck_q   <= 1'b1;
      frame_q <= 16'd0;
      done_q  <= 1'b0;
      timer_q <= 24'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sck_q   <= sck_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge SI_ClkIn) begin
    shreg_q <= shreg_d;
  end

  assign SPI_CS  = !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
  assign SPI_SCK = sck_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign frame   = frame_q;
  assign sample  = frame_q[11:4];

endmodule

// File: tb/tb_mfp_spi_sensor_sequencer.sv
// Bench for mfp_spi_sensor_sequencer: directed vectors, corner sequences and a
// randomized run against a transaction-offset reference model (CLK_DIV=2).
module tb_mfp_spi_sensor_sequencer;
  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req, auto_en, req2, auto_en2;
  logic sdo  = 1'b0;
  logic sdo2 = 1'b1;
  logic cs, sck, busy, done, cs2, sck2, busy2, done2;
  logic [15:0] frame, frame2;
  logic [7:0]  sample, sample2;

  mfp_spi_sensor_sequencer #(.CLK_DIV(D), .AUTO_PERIOD(100)) dut (
    .SI_ClkIn(clk), .SI_Reset(rst), .req(req), .auto_en(auto_en), .SPI_SDO(sdo),
    .SPI_CS(cs), .SPI_SCK(sck), .busy(busy), .done(done), .frame(frame), .sample(sample));

  mfp_spi_sensor_sequencer #(.CLK_DIV(D), .AUTO_PERIOD(64)) dut64 (
    .SI_ClkIn(clk), .SI_Reset(rst), .req(req2), .auto_en(auto_en2), .SPI_SDO(sdo2),
    .SPI_CS(cs2), .SPI_SCK(sck2), .busy(busy2), .done(done2), .frame(frame2), .sample(sample2));

  // Sensor model: presents the next bit MSB first on each falling SCK edge.
  logic [15:0] sdo_word = 16'h0;
  int fall_cnt = 0;
  always @(negedge sck or posedge cs) begin
    if (cs === 1'b1) fall_cnt = 0;
    else if (cs === 1'b0 && fall_cnt < 16) begin
      sdo = sdo_word[15 - fall_cnt];
      fall_cnt++;
    end
  end

  typedef struct {
    bit          active;
    int          off;
    int          timer;
    bit          pend;
    logic [15:0] frame;
    logic [15:0] word;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t s;
    s.active = 0; s.off = 0; s.timer = 0; s.pend = 0; s.frame = 16'h0; s.word = 16'h0;
    return s;
  endfunction

  function automatic mstate_t mstep(mstate_t s, bit rs, bit rq, bit ae, int per, logic [15:0] w);
    mstate_t n;
    bit st, wr;
    if (rs) return mreset();
    n  = s;
    st = !s.active && (rq || s.pend);
    wr = ae && (s.timer == per - 1);
    n.timer = (ae && !wr) ? s.timer + 1 : 0;
    n.pend  = (!ae || st) ? 1'b0 : (wr ? 1'b1 : s.pend);
    if (s.active) begin
      n.off = s.off + 1;
      if (n.off == 34 * D + 1) n.frame = s.word;
      if (n.off == 35 * D + 2) n.active = 0;
    end
    if (st) begin n.active = 1; n.off = 1; n.word = w; end
    return n;
  endfunction

  // Expected {cs, sck, busy, done, frame, sample} from cycles since the trigger.
  function automatic logic [27:0] mexp(mstate_t s);
    logic c, k, b, d;
    c = 1'b1; k = 1'b1; b = 1'b0; d = 1'b0;
    if (s.active) begin
      b = 1'b1;
      if (s.off <= 34 * D) c = 1'b0;
      if (s.off >= D + 1 && s.off <= 33 * D) k = (((s.off - D - 1) / D) % 2) == 1;
      d = (s.off == 34 * D + 1);
    end
    return {c, k, b, d, s.frame, s.frame[11:4]};
  endfunction

  typedef struct {
    int          cyc;
    logic        req;
    logic        cs, sck, busy, done;
    logic [15:0] frame;
  } vec_t;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  mstate_t m1, m2;
  logic [15:0] word_q[$];
  int fall_log[$], fall2_log[$];
  logic [7:0] sample_log[$];
  int done_cnt = 0, done2_cnt = 0;
  logic prev_cs, prev_sck, prev_done, prev_rst, prev_cs2;
  bit have_prev = 0, seen_fall = 0, aborted = 0;
  int cs_low_cnt = 0, cs_high_cnt = 0, rises = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic tick();
    logic [15:0] w;
    check("model_p100", 32'({cs, sck, busy, done, frame, sample}), 32'(mexp(m1)));
    check("model_p64", 32'({cs2, sck2, busy2, done2, frame2, sample2}), 32'(mexp(m2)));
    if (have_prev) begin
      if (sck !== prev_sck && !prev_rst) check("sck_only_cs_low", 32'({prev_cs, cs}), 32'd0);
      if (done === 1'b1) check("done_single_cycle", 32'(prev_done), 32'd0);
      if (prev_cs === 1'b1 && cs === 1'b0) begin
        if (seen_fall) check("cs_high_min2", 32'(cs_high_cnt >= 2), 32'd1);
        seen_fall = 1; cs_low_cnt = 0; rises = 0; aborted = 0;
        fall_log.push_back(cyc);
      end
      if (prev_cs === 1'b0 && cs === 1'b1 && !aborted) begin
        check("cs_low_68", 32'(cs_low_cnt), 32'd68);
        check("sck_rises_16", 32'(rises), 32'd16);
      end
      if (prev_cs2 === 1'b1 && cs2 === 1'b0) fall2_log.push_back(cyc);
    end
    if (cs === 1'b0) begin
      cs_low_cnt++;
      if (have_prev && sck === 1'b1 && prev_sck === 1'b0) rises++;
      if (rst) aborted = 1;
    end else begin
      if (prev_cs === 1'b0) cs_high_cnt = 0;
      cs_high_cnt++;
    end
    if (done === 1'b1) begin done_cnt++; sample_log.push_back(sample); end
    if (done2 === 1'b1) done2_cnt++;
    prev_cs = cs; prev_sck = sck; prev_done = done; prev_rst = rst; prev_cs2 = cs2;
    have_prev = 1;
    w = m1.word;
    if (!rst && !m1.active && (req || m1.pend)) begin
      w = (word_q.size() > 0) ? word_q.pop_front() : 16'($urandom);
      sdo_word = w;
    end
    m1 = mstep(m1, rst, req, auto_en, 100, w);
    m2 = mstep(m2, rst, req2, auto_en2, 64, 16'hFFFF);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t vt[15];
    int a, b, d0;
    vt[0]  = '{0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[2]  = '{2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[3]  = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[4]  = '{4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[5]  = '{5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[6]  = '{7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[7]  = '{64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[8]  = '{65, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[9]  = '{67, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[10] = '{68, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[11] = '{69, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0AB0};
    vt[12] = '{70, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0AB0};
    vt[13] = '{71, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0AB0};
    vt[14] = '{72, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0AB0};

    rst = 1'b1; req = 1'b0; auto_en = 1'b0; req2 = 1'b0; auto_en2 = 1'b0;
    m1 = mreset(); m2 = mreset();
    @(posedge clk);
    #1;
    tick(); tick();
    rst = 1'b0;
    check("reset_state", 32'({cs, sck, busy, done, frame, sample}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0}));
    repeat (3) tick();

    // Single read of 0x0AB0 from IDLE.
    word_q.push_back(16'h0AB0);
    for (int c = 0; c <= 72; c++) begin
      req = 1'b0;
      for (int i = 0; i < 15; i++) begin
        if (vt[i].cyc == c) begin
          req = vt[i].req;
          check($sformatf("single_read_c%0d", c), 32'({cs, sck, busy, done, frame}),
                32'({vt[i].cs, vt[i].sck, vt[i].busy, vt[i].done, vt[i].frame}));
        end
      end
      tick();
    end
    req = 1'b0;
    check("single_read_sample", 32'(sample), 32'h00AB);
    repeat (4) tick();

    // Reset in the middle of SHIFT.
    d0 = done_cnt;
    req = 1'b1; tick(); req = 1'b0;
    repeat (29) tick();
    check("pre_reset_cs_low", 32'(cs), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("reset_abort_outputs", 32'({cs, sck, busy, done, frame, sample}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0}));
    repeat (80) tick();
    check("reset_abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Request while busy is dropped.
    d0 = done_cnt; fall_log.delete();
    req = 1'b1; tick(); req = 1'b0;
    repeat (9) tick();
    req = 1'b1; tick(); req = 1'b0;
    repeat (100) tick();
    check("busy_req_dones", 32'(done_cnt - d0), 32'd1);
    check("busy_req_cs_falls", 32'(fall_log.size()), 32'd1);

    // Auto mode, 100-cycle period, frames 0xFFFF then 0x0000.
    fall_log.delete(); sample_log.delete();
    word_q.push_back(16'hFFFF); word_q.push_back(16'h0000);
    a = cyc; auto_en = 1'b1;
    repeat (280) tick();
    auto_en = 1'b0;
    repeat (80) tick();
    check("auto_cs_falls", 32'(fall_log.size()), 32'd2);
    check("auto_samples", 32'(sample_log.size()), 32'd2);
    if (fall_log.size() >= 2) begin
      check("auto_first_start", 32'(fall_log[0] - a), 32'd101);
      check("auto_period", 32'(fall_log[1] - fall_log[0]), 32'd100);
    end
    if (sample_log.size() >= 2) begin
      check("auto_sample0", 32'(sample_log[0]), 32'h00FF);
      check("auto_sample1", 32'(sample_log[1]), 32'h0000);
    end

    // req in the exact cycle the timer wraps: one transaction only.
    d0 = done_cnt; fall_log.delete();
    a = cyc; auto_en = 1'b1;
    repeat (99) tick();
    req = 1'b1; tick(); req = 1'b0;
    while (cyc < a + 190) tick();
    auto_en = 1'b0;
    repeat (100) tick();
    check("wrap_req_dones", 32'(done_cnt - d0), 32'd1);
    check("wrap_req_cs_falls", 32'(fall_log.size()), 32'd1);

    // Wrap during a transaction on the 64-cycle instance: one follow-up after QUIET.
    d0 = done2_cnt; fall2_log.delete();
    b = cyc; req2 = 1'b1; auto_en2 = 1'b1;
    tick(); req2 = 1'b0;
    while (cyc < b + 72) tick();
    auto_en2 = 1'b0;
    repeat (100) tick();
    check("coalesce_dones", 32'(done2_cnt - d0), 32'd2);
    check("coalesce_cs_falls", 32'(fall2_log.size()), 32'd2);
    if (fall2_log.size() >= 2) check("coalesce_followup_start", 32'(fall2_log[1] - b), 32'd73);

    // Randomized traffic against the reference model.
    auto_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      req  = ($urandom_range(0, 15) == 0);
      req2 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) auto_en  = ~auto_en;
      if ($urandom_range(0, 149) == 0) auto_en2 = ~auto_en2;
      tick();
    end
    rst = 1'b0; req = 1'b0; req2 = 1'b0; auto_en = 1'b0; auto_en2 = 1'b0;
    repeat (100) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mfp_spi_sensor_sequencer.md
MFP_SPI_SENSOR_SEQUENCER -- requirements
Module: mfp_spi_sensor_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in SI_ClkIn cycles; legal range 1..255.
REQ-002 SHALL have parameter AUTO_PERIOD, default 250000: auto-trigger interval in SI_ClkIn cycles; legal range 64..2^24-1.
REQ-003 SHALL have port SI_ClkIn  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port SI_Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1  single-shot read request, level-sampled.
REQ-006 SHALL have port auto_en  input  1  enables periodic auto-trigger.
REQ-007 SHALL have port SPI_SDO  input  1  serial data from the sensor ADC.
REQ-008 SHALL have port SPI_CS  output  1  chip select, active-low.
REQ-009 SHALL have port SPI_SCK  output  1  serial clock, idle high.
REQ-010 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-012 SHALL have port frame  output  16  last complete raw frame, MSB first.
REQ-013 SHALL have port sample  output  8  last sensor value, equal to frame[11:4].

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD, QUIET.
REQ-015 IDLE: SPI_CS=1, SPI_SCK=1, busy=0; on trigger, go to SETUP next cycle.
REQ-016 Trigger SHALL be req=1 OR auto_pending=1, sampled in IDLE only.
REQ-017 SETUP SHALL last CLK_DIV cycles, with SPI_CS=0, SPI_SCK=1, busy=1.
REQ-018 SHIFT SHALL toggle SPI_SCK every CLK_DIV cycles, starting with a falling edge, for exactly 16 low/high periods (32*CLK_DIV cycles).
REQ-019 SPI_SDO SHALL be captured into a 16-bit shift register on the cycle of each SPI_SCK rising edge, MSB first.
REQ-020 After the 16th rising edge, go to HOLD for CLK_DIV cycles with SPI_CS=0 and SPI_SCK=1.
REQ-021 On HOLD exit, in the same cycle: SPI_CS=1; frame and sample update; done=1 for exactly one cycle; enter QUIET.
REQ-022 SPI_CS low time SHALL be exactly 34*CLK_DIV cycles.
REQ-023 QUIET SHALL last CLK_DIV cycles with busy=1, then return to IDLE; this is the minimum CS-high time.
REQ-024 busy SHALL be high from the cycle SPI_CS falls through the last QUIET cycle.
REQ-025 req asserted while busy SHALL be ignored, not queued.
REQ-026 Auto timer: a 24-bit counter SHALL run while auto_en=1; when it reaches AUTO_PERIOD-1, it SHALL wrap to 0 and set auto_pending.
REQ-027 auto_pending SHALL clear when a transaction starts.
REQ-028 A timer wrap while busy SHALL set auto_pending, serviced at the next IDLE; at most one pending, and further wraps coalesce.
REQ-029 req and auto_pending together SHALL start one transaction and clear auto_pending.
REQ-030 auto_en=0 SHALL clear the timer and auto_pending the next cycle; an in-flight transaction still completes.
REQ-031 frame and sample SHALL hold their values between transactions and change only per REQ-021.

Reset
REQ-032 SI_Reset=1 at any clock edge SHALL force: FSM=IDLE, SPI_CS=1, SPI_SCK=1, busy=0, done=0, frame=0, sample=0, timer=0, auto_pending=0.
REQ-033 Reset mid-transaction SHALL abort without a done pulse and without updating frame or sample.
REQ-034 Reset SHALL take priority over all triggers in the same cycle.

Verification (CLK_DIV=2, AUTO_PERIOD=100)
REQ-035 Single read: req=1 at cycle 0 from IDLE, SDO model drives 0x0AB0 -> SPI_CS low cycles 1..68, 16 SCK rising edges, done at cycle 69, frame=0x0AB0, sample=0xAB, busy low from cycle 72.
REQ-036 Request while busy: req pulsed at cycle 10 during a transaction -> exactly one done pulse, no second transaction.
REQ-037 Auto mode: auto_en=1 held, req=0 -> a transaction starts every 100 cycles; model returns 0xFFFF then 0x0000 -> sample goes 0xFF, then 0x00.
REQ-038 Coalescing: AUTO_PERIOD=64 so the timer wraps during the transaction -> exactly one follow-up transaction, started right after QUIET; req at the same cycle as a wrap -> one transaction.
REQ-039 Reset mid-SHIFT at cycle 30 -> SPI_CS=1, SPI_SCK=1 the next cycle, no done pulse, frame and sample reset to 0.
REQ-040 Checkers: SCK toggles only while CS=0; CS low time is always 68 cycles; CS high time between transactions is at least 2 cycles; done is never asserted for 2 consecutive cycles.
